// File: rtl/fgba_bus_pkg.sv
// fgba_bus_pkg
// Shared definitions for the SoC memory bus: access-width encodings, the
// arbiter FSM state type and a helper that sizes index signals so that a
// single-entry vector still gets a 1-bit index.
// No ports (package).
package fgba_bus_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bus_state_t;

  // $clog2(1) is 0, which would give a zero-width index; clamp to 1 bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker
// Combinational winner select over a request vector.
//   PRIORITY_MODE = 0 : round-robin, first requester scanning upward from
//                       i_ptr+1 with wrap-around.
//   PRIORITY_MODE = 1 : fixed priority, lowest index wins.
// Ports:
//   i_req   [N-1:0]     request vector
//   i_ptr   [IDXW-1:0]  index of the last served requester
//   o_idx   [IDXW-1:0]  winning index (0 when nothing requests)
//   o_valid             at least one request is present
module rr_picker #(
  parameter int N             = 3,
  parameter int IDXW          = 2,
  parameter int PRIORITY_MODE = 0
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [IDXW-1:0] o_idx,
  output logic            o_valid
);

  // Loops run from the least-preferred candidate to the most-preferred one,
  // so the last hit written is the winner.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    if (PRIORITY_MODE != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_idx   = IDXW'(i);
          o_valid = 1'b1;
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        if (i_req[(int'(i_ptr) + k) % N]) begin
          o_idx   = IDXW'((int'(i_ptr) + k) % N);
          o_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// N-master arbiter in front of the single memory request port. One
// transaction at a time walks IDLE -> BUSY -> DONE; the downstream request
// is fully registered and each master gets a one-cycle m_ok pulse (plus
// m_err when the optional timeout fires).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m_addr/m_wdata      flattened per-master address / write data
//   m_width             flattened per-master width (0 byte, 1 half, 2 word)
//   m_read/m_write      per-master request strobes
//   m_ok/m_err          per-master completion / timeout pulses
//   m_rdata             shared read data, valid with the reader's m_ok
//   mem_addr/mem_wdata/mem_width/mem_read/mem_write  downstream request
//   mem_rdata/mem_ok    downstream response
//   grant               index of the current or last granted master
module mem_arbiter
  import fgba_bus_pkg::*;
#(
  parameter int NUM_MASTERS   = 3,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*2-1:0]        m_width,
  input  logic [NUM_MASTERS-1:0]          m_read,
  input  logic [NUM_MASTERS-1:0]          m_write,
  output logic [NUM_MASTERS-1:0]          m_ok,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [1:0]                      mem_width,
  output logic                            mem_read,
  output logic                            mem_write,
  input  logic [DATA_W-1:0]               mem_rdata,
  input  logic                            mem_ok,
  output logic [idxWidth(NUM_MASTERS)-1:0] grant
);

  localparam int          IDXW    = idxWidth(NUM_MASTERS);
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

  bus_state_t             r_state;
  bus_state_t             w_stateNext;
  logic [IDXW-1:0]        r_rrPtr;
  logic [31:0]            r_count;
  logic [NUM_MASTERS-1:0] w_req;
  logic [IDXW-1:0]        w_pickIdx;
  logic                   w_pickValid;
  logic                   w_launch;
  logic                   w_complete;
  logic                   w_abort;
  logic [NUM_MASTERS-1:0] w_grantOneHot;

  assign w_req         = m_read | m_write;
  assign w_grantOneHot = NUM_MASTERS'(1) << grant;

  rr_picker #(
    .N             (NUM_MASTERS),
    .IDXW          (IDXW),
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_picker (
    .i_req   (w_req),
    .i_ptr   (r_rrPtr),
    .o_idx   (w_pickIdx),
    .o_valid (w_pickValid)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNext;
  end

  // mem_ok has priority over the timeout when both land in the same cycle.
  // DONE never looks at requests, so the master just completed cannot be
  // re-issued before it has had a cycle to drop its strobe.
  always_comb begin
    w_stateNext = r_state;
    w_launch    = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pickValid) begin
          w_launch    = 1'b1;
          w_stateNext = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ok) begin
          w_complete  = 1'b1;
          w_stateNext = ST_DONE;
        end else if (TO_EN && (r_count == TO_LAST)) begin
          w_abort     = 1'b1;
          w_stateNext = ST_DONE;
        end
      end
      ST_DONE: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Datapath: captures the winner's request, returns the response and
  // advances the round-robin pointer to the master just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_width <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      m_ok      <= '0;
      m_err     <= '0;
      m_rdata   <= '0;
      grant     <= '0;
      r_count   <= '0;
      r_rrPtr   <= IDXW'(NUM_MASTERS - 1);
    end else begin
      m_ok  <= '0;
      m_err <= '0;
      if (w_launch) begin
        mem_addr  <= m_addr[w_pickIdx*ADDR_W +: ADDR_W];
        mem_wdata <= m_wdata[w_pickIdx*DATA_W +: DATA_W];
        mem_width <= m_width[w_pickIdx*2 +: 2];
        mem_write <= m_write[w_pickIdx];
        mem_read  <= m_read[w_pickIdx] & ~m_write[w_pickIdx];
        grant     <= w_pickIdx;
        r_count   <= '0;
      end else if (r_state == ST_BUSY) begin
        r_count <= r_count + 32'd1;
      end
      if (w_complete || w_abort) begin
        m_ok      <= w_grantOneHot;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        r_rrPtr   <= grant;
      end
      if (w_complete && mem_read) m_rdata <= mem_rdata;
      if (w_abort) begin
        m_err   <= w_grantOneHot;
        m_rdata <= '1;
      end
    end
  end

endmodule
